pc_redirect: RTL and testbench
==============================

# pc_redirect

Fetch-side program counter and redirect controller for the pipelined core. Consumes the execute-stage branch/jump-taken decision and target, owns the architectural fetch PC, and issues the one-cycle flush of younger pipeline registers when control flow changes. Holds a pending redirect across hazard stalls, freezes on HALT or a misaligned target, and keeps a saturating count of taken redirects for performance checks.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- CNT_W, 16, width of the taken-redirect counter

- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  global pipeline hold from the hazard/memory unit
- ex_valid  in  1  EX stage holds a real instruction this cycle
- ex_taken  in  1  branch/jump taken decision for the EX instruction
- ex_target  in  16  resolved target address for the EX instruction
- ex_halt  in  1  EX instruction is HALT
- pc  out  16  current fetch address (registered)
- pc_plus2  out  16  pc + 2, modulo 2^16
- fetch_valid  out  1  fetch address is live; low in HALT
- flush  out  1  kill IF/ID and ID/EX contents on this edge
- misalign_err  out  1  sticky; set by an odd redirect target
- redirect_cnt  out  CNT_W  saturating count of fired redirects

## Operation
- States: RUN, PEND, HALT. Reset: state=RUN, pc=RESET_PC, pend_target=0, misalign_err=0, redirect_cnt=0, flush=0, fetch_valid=1.
- take = ex_valid & ex_taken; hlt = ex_valid & ex_halt; bad = take & ex_target[0].
- RUN, priority order:
  - hlt -> HALT; pc holds; no flush (halt wins over take in the same cycle).
  - bad -> misalign_err<=1, HALT; pc holds; no flush; counter unchanged.
  - take & ~stall -> fire: pc<=ex_target, flush=1, counter+1; stay RUN.
  - take & stall -> pend_target<=ex_target, PEND; pc holds; flush=0.
  - ~take & ~stall -> pc<=pc+2 (wraps 0xFFFE -> 0x0000).
  - stall, no event -> pc holds.
- PEND: all ex_* inputs ignored (EX re-presents the same instruction during stall).
  - stall -> hold.
  - ~stall -> fire: pc<=pend_target, flush=1, counter+1, -> RUN.
- HALT: pc, counter, pend_target frozen; fetch_valid=0; flush=0; ex_* and stall ignored; exit only by reset.
- Counter saturates at all-ones; fire at saturation leaves it unchanged.
- pc_plus2 is combinational from pc.

## Timing
- flush is combinational, asserted only in the cycle a redirect fires, so younger pipeline registers capture NOPs on the same edge that pc loads the target; first fetch from the target occurs the following cycle.
- Redirect latency: ex_taken with stall low -> pc==target one edge later. With stall high, pc==target one edge after the first cycle stall is low.
- misalign_err and HALT entry visible one edge after the triggering cycle; fetch_valid drops on that same edge.
- rst_n assertion at any point, including in PEND with a latched target, returns all outputs to reset values immediately; the pending redirect is discarded.
- No output depends combinationally on stall except flush.

## Structure
- Shared package: state enum (RUN, PEND, HALT), PC_W=16 constant, RESET_PC default, instruction alignment constant (2 bytes).
- One sub-module: sat_cnt (parameterised CNT_W, inc enable, async active-low clear) for redirect_cnt.
- Remainder in pc_redirect: state register, pc register, pend_target register, next-pc mux.

## Test plan
- Reset then 4 cycles no stall, no branch -> pc sequence 0x0000, 0x0002, 0x0004, 0x0006; flush never high.
- At pc=0x0010, take with target 0x0100, stall=0 -> flush=1 that cycle, pc=0x0100 next edge, redirect_cnt=1.
- Take target 0x0200 with stall high for 3 cycles, ex_target changed to 0x0300 during stall -> pc holds, no flush, then pc=0x0200 and flush one cycle after stall drops.
- Take with target 0x0101 -> misalign_err=1, fetch_valid=0, pc frozen; later take with target 0x0400 -> no change.
- ex_halt and ex_taken together -> HALT, no flush, counter unchanged; pc at 0xFFFE free-running -> wraps to 0x0000; CNT_W=2 bench: 5 fires -> redirect_cnt=3.
- rst_n low mid-PEND -> pc=RESET_PC, state RUN, flush=0; after release, no stale redirect fires.

Source files
------------

// File: rtl/pc_redirect_pkg.sv
// Shared types and constants for the fetch PC / redirect controller.
package pc_redirect_pkg;

  localparam int unsigned PC_W = 16;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  // Instruction size in bytes; sequential fetch advances by this much.
  localparam logic [PC_W-1:0] INSN_ALIGN = 16'd2;

  typedef enum logic [1:0] {
    StRun,
    StPend,
    StHalt
  } state_e;

endpackage

// File: rtl/pc_redirect_if.sv
// EX-side decision inputs and fetch-side outputs of the PC redirect controller.
interface pc_redirect_if #(
  parameter int unsigned CNT_W = 16
);
  import pc_redirect_pkg::*;

  logic            stall;
  logic            ex_valid;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic            ex_halt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus2;
  logic            fetch_valid;
  logic            flush;
  logic            misalign_err;
  logic [CNT_W-1:0] redirect_cnt;

  // Pipeline/hazard side: drives the EX decision, observes fetch state.
  modport master (
    output stall, ex_valid, ex_taken, ex_target, ex_halt,
    input  pc, pc_plus2, fetch_valid, flush, misalign_err, redirect_cnt
  );

  // Redirect controller side.
  modport slave (
    input  stall, ex_valid, ex_taken, ex_target, ex_halt,
    output pc, pc_plus2, fetch_valid, flush, misalign_err, redirect_cnt
  );

endinterface

// File: rtl/pc_redirect_sat_cnt.sv
// Saturating up-counter with asynchronous active-low clear.
module pc_redirect_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  // Count up on inc, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pc_redirect.sv
// Fetch PC owner: sequential advance, taken-branch redirect with flush,
// redirect held across stalls, freeze on HALT or misaligned target.
module pc_redirect
  import pc_redirect_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     CNT_W    = 16
) (
  input logic          clk,
  input logic          rst_n,
  pc_redirect_if.slave bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic            misalign_q, misalign_d;
  logic            fire;
  logic            take, hlt, bad;

  assign take = bus.ex_valid & bus.ex_taken;
  assign hlt  = bus.ex_valid & bus.ex_halt;
  assign bad  = take & bus.ex_target[0];

  // State, PC, pending target and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state and next-PC selection; fire marks the cycle a redirect lands.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    misalign_d = misalign_q;
    fire       = 1'b0;
    unique case (state_q)
      StRun: begin
        if (hlt) begin
          // Halt outranks a same-cycle taken branch.
          state_d = StHalt;
        end else if (bad) begin
          misalign_d = 1'b1;
          state_d    = StHalt;
        end else if (take) begin
          if (bus.stall) begin
            pend_d  = bus.ex_target;
            state_d = StPend;
          end else begin
            fire = 1'b1;
            pc_d = bus.ex_target;
          end
        end else if (!bus.stall) begin
          pc_d = pc_q + INSN_ALIGN;
        end
      end
      StPend: begin
        // EX re-presents the same instruction while stalled; ignore it.
        if (!bus.stall) begin
          fire    = 1'b1;
          pc_d    = pend_q;
          state_d = StRun;
        end
      end
      StHalt: begin
        // Frozen until reset.
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  pc_redirect_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fire),
    .cnt   (bus.redirect_cnt)
  );

  assign bus.pc           = pc_q;
  assign bus.pc_plus2     = pc_q + INSN_ALIGN;
  assign bus.fetch_valid  = (state_q != StHalt);
  assign bus.flush        = fire;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_redirect.sv
// Directed bench for pc_redirect with a 2-bit redirect counter.
module tb_pc_redirect;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pc_redirect_if #(.CNT_W(2)) bus ();

  pc_redirect #(
    .RESET_PC (16'h0000),
    .CNT_W    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic t, input logic [15:0] tgt,
                       input logic h, input logic s);
    bus.ex_valid  = v;
    bus.ex_taken  = t;
    bus.ex_target = tgt;
    bus.ex_halt   = h;
    bus.stall     = s;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic reset_dut();
    idle();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    idle();
    #1;
    // Reset state while held in reset.
    check("rst_pc", 32'(bus.pc), 32'h0000);
    check("rst_fv", 32'(bus.fetch_valid), 32'd1);
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_mis", 32'(bus.misalign_err), 32'd0);
    check("rst_cnt", 32'(bus.redirect_cnt), 32'd0);
    check("rst_pc2", 32'(bus.pc_plus2), 32'h0002);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Sequential fetch.
    for (int i = 1; i <= 3; i++) begin
      check("seq_flush", 32'(bus.flush), 32'd0);
      tick();
      check("seq_pc", 32'(bus.pc), 32'(2 * i));
    end
    for (int i = 0; i < 5; i++) tick();
    check("pc_0x10", 32'(bus.pc), 32'h0010);

    // Unstalled taken branch.
    drive(1'b1, 1'b1, 16'h0100, 1'b0, 1'b0);
    #1;
    check("take_flush", 32'(bus.flush), 32'd1);
    tick();
    idle();
    #1;
    check("take_pc", 32'(bus.pc), 32'h0100);
    check("take_cnt", 32'(bus.redirect_cnt), 32'd1);
    check("take_flush_off", 32'(bus.flush), 32'd0);

    // Taken under a 3-cycle stall; target changes during the stall.
    drive(1'b1, 1'b1, 16'h0200, 1'b0, 1'b1);
    #1;
    check("pend_flush0", 32'(bus.flush), 32'd0);
    tick();
    drive(1'b1, 1'b1, 16'h0300, 1'b0, 1'b1);
    check("pend_pc1", 32'(bus.pc), 32'h0100);
    tick();
    check("pend_pc2", 32'(bus.pc), 32'h0100);
    check("pend_flush2", 32'(bus.flush), 32'd0);
    tick();
    check("pend_pc3", 32'(bus.pc), 32'h0100);
    drive(1'b1, 1'b1, 16'h0300, 1'b0, 1'b0);
    #1;
    check("pend_fire_flush", 32'(bus.flush), 32'd1);
    tick();
    idle();
    #1;
    check("pend_fire_pc", 32'(bus.pc), 32'h0200);
    check("pend_cnt", 32'(bus.redirect_cnt), 32'd2);
    tick();
    check("after_pend_pc", 32'(bus.pc), 32'h0202);

    // Fires 3..5 saturate the 2-bit counter at 3.
    drive(1'b1, 1'b1, 16'h0400, 1'b0, 1'b0);
    tick();
    check("cnt3", 32'(bus.redirect_cnt), 32'd3);
    drive(1'b1, 1'b1, 16'h0500, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    check("cnt_sat", 32'(bus.redirect_cnt), 32'd3);
    check("pc_fffe", 32'(bus.pc), 32'hFFFE);
    check("pc2_wrap", 32'(bus.pc_plus2), 32'h0000);
    tick();
    check("pc_wrap", 32'(bus.pc), 32'h0000);

    // Reset in the middle of a pending redirect.
    drive(1'b1, 1'b1, 16'h0800, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("prst_pc", 32'(bus.pc), 32'h0000);
    check("prst_flush", 32'(bus.flush), 32'd0);
    check("prst_cnt", 32'(bus.redirect_cnt), 32'd0);
    check("prst_fv", 32'(bus.fetch_valid), 32'd1);
    bus.stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("prst_noflush", 32'(bus.flush), 32'd0);
    tick();
    check("prst_seq", 32'(bus.pc), 32'h0002);
    tick();

    // Halt together with take: halt wins, no flush.
    drive(1'b1, 1'b1, 16'h0100, 1'b1, 1'b0);
    #1;
    check("halt_flush", 32'(bus.flush), 32'd0);
    tick();
    idle();
    #1;
    check("halt_fv", 32'(bus.fetch_valid), 32'd0);
    check("halt_pc", 32'(bus.pc), 32'h0004);
    check("halt_cnt", 32'(bus.redirect_cnt), 32'd0);
    check("halt_mis", 32'(bus.misalign_err), 32'd0);
    drive(1'b1, 1'b1, 16'h0400, 1'b0, 1'b0);
    #1;
    check("halt_take_flush", 32'(bus.flush), 32'd0);
    tick();
    check("halt_frozen", 32'(bus.pc), 32'h0004);

    // Misaligned target.
    reset_dut();
    tick();
    drive(1'b1, 1'b1, 16'h0101, 1'b0, 1'b0);
    #1;
    check("mis_flush", 32'(bus.flush), 32'd0);
    tick();
    idle();
    #1;
    check("mis_err", 32'(bus.misalign_err), 32'd1);
    check("mis_fv", 32'(bus.fetch_valid), 32'd0);
    check("mis_pc", 32'(bus.pc), 32'h0002);
    check("mis_cnt", 32'(bus.redirect_cnt), 32'd0);
    drive(1'b1, 1'b1, 16'h0400, 1'b0, 1'b0);
    #1;
    check("mis_take_flush", 32'(bus.flush), 32'd0);
    tick();
    check("mis_frozen", 32'(bus.pc), 32'h0002);
    check("mis_sticky", 32'(bus.misalign_err), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
